// File: rtl/if_fetch_unit_pkg.sv
// Types and PC helpers shared by the fetch unit and its prefetch FIFO.
`include "defines.sv"

package if_fetch_unit_pkg;

   typedef enum logic {
      IF_FETCH = `IF_STATE_FETCH,
      IF_FLUSH = `IF_STATE_FLUSH
   } if_state_e;

   typedef struct packed {
      logic [`MEM_ADDR_WIDTH-1:0] pc;
      logic [`REG_DATA_WIDTH-1:0] inst;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   // Sequential fetch; wraps modulo the address space.
   function automatic logic [`MEM_ADDR_WIDTH-1:0] pc_incr(input logic [`MEM_ADDR_WIDTH-1:0] pc);
      return pc + `MEM_ADDR_WIDTH'(4);
   endfunction

   function automatic logic [`MEM_ADDR_WIDTH-1:0] align_pc(input logic [`MEM_ADDR_WIDTH-1:0] target);
      return target & ~`MEM_ADDR_WIDTH'(3);
   endfunction

endpackage

// File: rtl/defines.sv
// Shared widths, stall codes and fetch-stage encodings for the core pipeline.
`ifndef IF_DEFINES_SV
`define IF_DEFINES_SV

`define MEM_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32

`define STALL_WIDTH  2
`define STALL_NONE   2'b00
`define STALL_LOAD   2'b01
`define STALL_BRANCH 2'b10

`define IF_STATE_FETCH 1'b0
`define IF_STATE_FLUSH 1'b1

`define NOP_INST 32'b0

`endif

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2.
module if_prefetch_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [DATA_W-1:0]      wdata,
   input  logic                   pop,
   output logic [DATA_W-1:0]      rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && !flush && push && !pop)
         assert (count < CNT_W'(DEPTH)) else $error("if_prefetch_fifo overflow");
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC ownership, in-order imem requests, prefetch buffering, redirect flush.
// Optional IF_PERF_CNT_EN adds saturating bubble and flush counters.
`include "defines.sv"

module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [`MEM_ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                         FIFO_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [`STALL_WIDTH-1:0]    stall,
   input  logic                       branch_taken,
   input  logic [`MEM_ADDR_WIDTH-1:0] branch_target,
   output logic                       imem_req,
   output logic [`MEM_ADDR_WIDTH-1:0] imem_addr,
   input  logic                       imem_gnt,
   input  logic                       imem_rvalid,
   input  logic [`REG_DATA_WIDTH-1:0] imem_rdata,
   output logic [`MEM_ADDR_WIDTH-1:0] PC_if,
   output logic [`REG_DATA_WIDTH-1:0] inst_if,
   output logic                       if_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]                perf_bubble_cnt,
   output logic [31:0]                perf_flush_cnt
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int USE_W = CNT_W + 1;

   if_state_e                  state, state_nxt;
   logic [`MEM_ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
   logic [CNT_W-1:0]           drop_cnt, drop_cnt_nxt;
   logic [CNT_W-1:0]           fifo_count, tag_count, outstanding;
   logic [USE_W-1:0]           in_use;
   logic [`MEM_ADDR_WIDTH-1:0] tag_head;
   fetch_entry_t               head, push_entry;
   logic                       fifo_empty, issue, keep, pop;

   // Live requests sit in the tag FIFO; requests orphaned by a redirect are only counted.
   assign outstanding = tag_count + drop_cnt;
   assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
   assign fifo_empty  = (fifo_count == '0);
   assign issue       = imem_req && imem_gnt;
   assign keep        = imem_rvalid && (drop_cnt == '0) && !branch_taken;
   assign pop         = !fifo_empty && (stall != `STALL_LOAD) && !branch_taken;
   assign push_entry  = '{pc: tag_head, inst: imem_rdata};

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      drop_cnt_nxt = drop_cnt;
      imem_req     = 1'b0;
      if (branch_taken) begin
         fetch_pc_nxt = align_pc(branch_target);
         drop_cnt_nxt = outstanding - CNT_W'(imem_rvalid && (outstanding != '0));
         state_nxt    = (drop_cnt_nxt != '0) ? IF_FLUSH : IF_FETCH;
      end else begin
         case (state)
            IF_FETCH: begin
               imem_req = !rst && (in_use < USE_W'(FIFO_DEPTH));
               if (imem_req && imem_gnt) fetch_pc_nxt = pc_incr(fetch_pc);
            end
            IF_FLUSH: begin
               if (imem_rvalid && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - CNT_W'(1);
               if (drop_cnt_nxt == '0) state_nxt = IF_FETCH;
            end
            default: state_nxt = IF_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IF_FETCH;
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         drop_cnt <= drop_cnt_nxt;
      end
   end

   if_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(ENTRY_W)) u_inst_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_taken),
      .push  (keep),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count)
   );

   // PC tags of issued requests, consumed in response order.
   if_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(`MEM_ADDR_WIDTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_taken),
      .push  (issue),
      .wdata (fetch_pc),
      .pop   (keep),
      .rdata (tag_head),
      .count (tag_count)
   );

   assign imem_addr = fetch_pc;
   assign if_valid  = !fifo_empty;
   assign inst_if   = fifo_empty ? `NOP_INST : head.inst;
   assign PC_if     = fifo_empty ? fetch_pc  : head.pc;

`ifdef IF_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubble_cnt <= '0;
         perf_flush_cnt  <= '0;
      end else begin
         if (!if_valid && (stall != `STALL_LOAD)) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
         if (branch_taken)                        perf_flush_cnt  <= sat_inc(perf_flush_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one instance at RESET_PC 0, one near the top of the address space.
module tb_if_fetch_unit;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PC_if;
   logic [31:0] inst_if;
   logic        if_valid;

   logic [1:0]  w_stall;
   logic        w_branch;
   logic [31:0] w_target;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_gnt;
   logic        w_rvalid;
   logic [31:0] w_rdata;
   logic [31:0] w_pc;
   logic [31:0] w_inst;
   logic        w_valid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_bubble_cnt, perf_flush_cnt, w_perf_bubble, w_perf_flush;
`endif

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PC_if(PC_if), .inst_if(inst_if), .if_valid(if_valid)
`ifdef IF_PERF_CNT_EN
      , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
      .clk(clk), .rst(rst), .stall(w_stall), .branch_taken(w_branch),
      .branch_target(w_target), .imem_req(w_req), .imem_addr(w_addr),
      .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .PC_if(w_pc), .inst_if(w_inst), .if_valid(w_valid)
`ifdef IF_PERF_CNT_EN
      , .perf_bubble_cnt(w_perf_bubble), .perf_flush_cnt(w_perf_flush)
`endif
   );

   // Instruction memory models: fixed latency (1 or 2 cycles), word = addr ^ A5A5_0000.
   int          lat;
   logic        m_p1_v, m_p2_v, w_p1_v;
   logic [31:0] m_p1_a, m_p2_a, w_p1_a;

   always @(posedge clk) begin
      if (rst) begin
         m_p1_v <= 1'b0;
         m_p2_v <= 1'b0;
         w_p1_v <= 1'b0;
      end else begin
         m_p1_v <= imem_req && imem_gnt;
         m_p2_v <= m_p1_v;
         w_p1_v <= w_req && w_gnt;
      end
      m_p1_a <= imem_addr;
      m_p2_a <= m_p1_a;
      w_p1_a <= w_addr;
   end

   assign imem_rvalid = (lat == 1) ? m_p1_v : m_p2_v;
   assign imem_rdata  = ((lat == 1) ? m_p1_a : m_p2_a) ^ 32'hA5A5_0000;
   assign w_rvalid    = w_p1_v;
   assign w_rdata     = w_p1_a ^ 32'hA5A5_0000;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, {31'b0, obs}, {31'b0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l);
      rst          = 1'b1;
      lat          = l;
      stall        = ST_NONE;
      branch_taken = 1'b0;
      imem_gnt     = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = ST_NONE; branch_taken = 1'b0; branch_target = '0;
      imem_gnt = 1'b1; lat = 1;
      w_stall = ST_NONE; w_branch = 1'b0; w_target = '0; w_gnt = 1'b1;

      // Reset values
      tick();
      check1("rst_req", imem_req, 1'b0);
      check ("rst_pc", PC_if, 32'h0);
      check ("rst_inst", inst_if, 32'h0);
      check1("rst_valid", if_valid, 1'b0);
      check ("rst_wrap_pc", w_pc, 32'hFFFF_FFF8);
      check1("rst_wrap_req", w_req, 1'b0);
      rst = 1'b0;
      #1;

      // Streaming, latency 1
      check1("c0_req", imem_req, 1'b1);
      check ("c0_addr", imem_addr, 32'h0);
      check1("c0_valid", if_valid, 1'b0);
      check ("c0_waddr", w_addr, 32'hFFFF_FFF8);
      tick(); #1;
      check ("c1_addr", imem_addr, 32'h4);
      check1("c1_valid", if_valid, 1'b0);
      check ("c1_waddr", w_addr, 32'hFFFF_FFFC);
      tick(); #1;
      check1("c2_valid", if_valid, 1'b1);
      check ("c2_pc", PC_if, 32'h0);
      check ("c2_inst", inst_if, 32'hA5A5_0000);
      check1("c2_req", imem_req, 1'b0);
      check ("c2_wpc", w_pc, 32'hFFFF_FFF8);
      check ("c2_winst", w_inst, 32'h5A5A_FFF8);
      tick(); #1;
      check ("c3_pc", PC_if, 32'h4);
      check ("c3_inst", inst_if, 32'hA5A5_0004);
      check ("c3_addr", imem_addr, 32'h8);
      check ("c3_wpc", w_pc, 32'hFFFF_FFFC);
      check ("c3_waddr", w_addr, 32'h0);
      tick(); #1;
      check1("c4_valid", if_valid, 1'b0);
      check ("c4_inst", inst_if, 32'h0);
      check ("c4_pc", PC_if, 32'hC);
      check ("c4_wpc", w_pc, 32'h4);

      // Load stall while PC 8 is at the head
      tick(); stall = ST_LOAD; #1;
      check ("c5_pc", PC_if, 32'h8);
      check ("c5_inst", inst_if, 32'hA5A5_0008);
      check ("c5_wpc", w_pc, 32'h0);
      check ("c5_winst", w_inst, 32'hA5A5_0000);
      tick(); #1;
      check ("c6_pc", PC_if, 32'h8);
      check1("c6_req", imem_req, 1'b0);
      tick(); #1;
      check ("c7_pc", PC_if, 32'h8);
      check ("c7_inst", inst_if, 32'hA5A5_0008);
      check1("c7_req", imem_req, 1'b0);
      tick(); stall = ST_NONE; #1;
      check ("c8_pc", PC_if, 32'h8);
      check1("c8_valid", if_valid, 1'b1);
      tick(); #1;
      check ("c9_pc", PC_if, 32'hC);
      check ("c9_inst", inst_if, 32'hA5A5_000C);
      check1("c9_req", imem_req, 1'b1);
      check ("c9_addr", imem_addr, 32'h10);

      // Redirect with two outstanding and a response in the redirect cycle (latency 2)
      do_reset(2);
      check ("d0_addr", imem_addr, 32'h0);
      tick(); #1;
      check1("d1_req", imem_req, 1'b1);
      check ("d1_addr", imem_addr, 32'h4);
      tick(); branch_taken = 1'b1; branch_target = 32'h0000_0102; #1;
      check1("d2_req", imem_req, 1'b0);
      tick(); branch_taken = 1'b0; #1;
      check1("d3_req", imem_req, 1'b0);
      check ("d3_inst", inst_if, 32'h0);
      check1("d3_valid", if_valid, 1'b0);
      check ("d3_pc", PC_if, 32'h100);
      tick(); #1;
      check1("d4_req", imem_req, 1'b1);
      check ("d4_addr", imem_addr, 32'h100);
      tick(); #1;
      check ("d5_addr", imem_addr, 32'h104);
      tick(); #1;
      check1("d6_req", imem_req, 1'b0);
      tick(); #1;
      check ("d7_pc", PC_if, 32'h100);
      check ("d7_inst", inst_if, 32'hA5A5_0100);
      check1("d7_valid", if_valid, 1'b1);

      // Grant withheld for 4 cycles
      do_reset(1);
      imem_gnt = 1'b0; #1;
      check1("e0_req", imem_req, 1'b1);
      check ("e0_addr", imem_addr, 32'h0);
      tick(); #1;
      tick(); #1;
      tick(); #1;
      check1("e3_req", imem_req, 1'b1);
      check ("e3_addr", imem_addr, 32'h0);
      check1("e3_valid", if_valid, 1'b0);
      check ("e3_inst", inst_if, 32'h0);
      tick(); imem_gnt = 1'b1; #1;
      tick(); #1;
      check ("e5_addr", imem_addr, 32'h4);
      tick(); #1;
      check ("e6_pc", PC_if, 32'h0);
      check ("e6_inst", inst_if, 32'hA5A5_0000);
      check1("e6_valid", if_valid, 1'b1);

`ifdef IF_PERF_CNT_EN
      // Three redirects and five empty cycles
      do_reset(1);
      imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0200; #1;
      tick(); #1;
      tick(); #1;
      tick(); branch_taken = 1'b0; #1;
      check ("f3_addr", imem_addr, 32'h200);
      tick(); #1;
      tick(); #1;
      check ("f5_flush_cnt", perf_flush_cnt, 32'd3);
      check ("f5_bubble_cnt", perf_bubble_cnt, 32'd5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
